// File: rtl/lcd_controller.sv
// HD44780-style character LCD write controller.
// After power-up it plays a fixed six-command init sequence, then accepts
// one command/character write at a time over a valid/ready handshake.
// Every LCD write is SETUP (2 clocks) -> PULSE (EN_CYCLES clocks) -> HOLD.
// For writes that return to IDLE, the final clock of the post-write wait is
// spent in IDLE with req_ready=1. That lets a held req_valid be accepted on
// the clock the wait ends, with no extra idle clock. Between init entries
// HOLD runs the full wait, because there is no handshake cycle to fold in.
module lcd_controller #(
  parameter int POWERUP_CYCLES = 750000,
  parameter int EN_CYCLES      = 12,
  parameter int SHORT_WAIT     = 2000,
  parameter int LONG_WAIT      = 82000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_rs,
  input  logic [7:0] req_data,
  output logic       init_done,
  output logic [7:0] lcd_data,
  output logic       lcd_en,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_on,
  output logic       lcd_blon
);

  localparam int MAX_PL  = (POWERUP_CYCLES > LONG_WAIT) ? POWERUP_CYCLES : LONG_WAIT;
  localparam int MAX_PLS = (MAX_PL > SHORT_WAIT) ? MAX_PL : SHORT_WAIT;
  localparam int MAX_ALL = (MAX_PLS > EN_CYCLES) ? MAX_PLS : EN_CYCLES;
  localparam int CNT_W   = $clog2(MAX_ALL + 1);

  localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_TWO    = CNT_W'(2);
  localparam logic [CNT_W-1:0] PU_LAST    = CNT_W'(POWERUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(1);
  localparam logic [CNT_W-1:0] EN_LAST    = CNT_W'(EN_CYCLES - 1);
  localparam logic [CNT_W-1:0] SHORT_LEN  = CNT_W'(SHORT_WAIT);
  localparam logic [CNT_W-1:0] LONG_LEN   = CNT_W'(LONG_WAIT);
  localparam logic [2:0]       LAST_IDX   = 3'd5;

  typedef enum logic [2:0] {
    ST_POWERUP = 3'd0,
    ST_SETUP   = 3'd1,
    ST_PULSE   = 3'd2,
    ST_HOLD    = 3'd3,
    ST_IDLE    = 3'd4
  } state_t;

  state_t           state_r, state_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic [2:0]       idx_r, idx_s;
  logic             long_r, long_s;
  logic             en_s, rs_s, ready_s, done_s;
  logic [7:0]       data_s;
  logic [CNT_W-1:0] wait_len_s;

  // Init command ROM: function set x3, display on, clear, entry mode.
  function automatic logic [7:0] init_byte(input logic [2:0] i);
    logic [7:0] b;
    case (i)
      3'd0:    b = 8'h38;
      3'd1:    b = 8'h38;
      3'd2:    b = 8'h38;
      3'd3:    b = 8'h0C;
      3'd4:    b = 8'h01;
      3'd5:    b = 8'h06;
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  // Clear-display and return-home commands need the long execution wait.
  function automatic logic needs_long(input logic rs, input logic [7:0] d);
    return (rs == 1'b0) && ((d == 8'h01) || (d == 8'h02) || (d == 8'h03));
  endfunction

  // Next-state and next-output logic for the write sequencer.
  always_comb begin
    state_s    = state_r;
    cnt_s      = cnt_r;
    idx_s      = idx_r;
    long_s     = long_r;
    en_s       = lcd_en;
    rs_s       = lcd_rs;
    data_s     = lcd_data;
    ready_s    = req_ready;
    done_s     = init_done;
    wait_len_s = long_r ? LONG_LEN : SHORT_LEN;
    case (state_r)
      ST_POWERUP: begin
        if (cnt_r == PU_LAST) begin
          state_s = ST_SETUP;
          cnt_s   = CNT_ZERO;
          idx_s   = 3'd0;
          rs_s    = 1'b0;
          data_s  = init_byte(3'd0);
          long_s  = needs_long(1'b0, init_byte(3'd0));
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      ST_SETUP: begin
        if (cnt_r == SETUP_LAST) begin
          state_s = ST_PULSE;
          cnt_s   = CNT_ZERO;
          en_s    = 1'b1;
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      ST_PULSE: begin
        if (cnt_r == EN_LAST) begin
          state_s = ST_HOLD;
          cnt_s   = CNT_ZERO;
          en_s    = 1'b0;
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      ST_HOLD: begin
        if (!init_done && (idx_r != LAST_IDX)) begin
          // More init entries: full wait, then load the next one.
          if (cnt_r == (wait_len_s - CNT_ONE)) begin
            state_s = ST_SETUP;
            cnt_s   = CNT_ZERO;
            idx_s   = idx_r + 3'd1;
            rs_s    = 1'b0;
            data_s  = init_byte(idx_r + 3'd1);
            long_s  = needs_long(1'b0, init_byte(idx_r + 3'd1));
          end else begin
            cnt_s = cnt_r + CNT_ONE;
          end
        end else begin
          // Returning to IDLE: the IDLE clock is the last clock of the wait.
          if (cnt_r == (wait_len_s - CNT_TWO)) begin
            state_s = ST_IDLE;
            cnt_s   = CNT_ZERO;
            done_s  = 1'b1;
            ready_s = 1'b1;
          end else begin
            cnt_s = cnt_r + CNT_ONE;
          end
        end
      end
      ST_IDLE: begin
        if (req_valid && req_ready) begin
          state_s = ST_SETUP;
          cnt_s   = CNT_ZERO;
          rs_s    = req_rs;
          data_s  = req_data;
          long_s  = needs_long(req_rs, req_data);
          ready_s = 1'b0;
        end else begin
          ready_s = init_done;
        end
      end
      default: begin
        state_s = ST_POWERUP;
        cnt_s   = CNT_ZERO;
        idx_s   = 3'd0;
        en_s    = 1'b0;
        ready_s = 1'b0;
        done_s  = 1'b0;
      end
    endcase
  end

  // State, counters and all outputs are registered here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_POWERUP;
      cnt_r     <= CNT_ZERO;
      idx_r     <= 3'd0;
      long_r    <= 1'b0;
      lcd_en    <= 1'b0;
      lcd_rs    <= 1'b0;
      lcd_data  <= 8'h00;
      lcd_on    <= 1'b0;
      lcd_rw    <= 1'b0;
      lcd_blon  <= 1'b0;
      req_ready <= 1'b0;
      init_done <= 1'b0;
    end else begin
      state_r   <= state_s;
      cnt_r     <= cnt_s;
      idx_r     <= idx_s;
      long_r    <= long_s;
      lcd_en    <= en_s;
      lcd_rs    <= rs_s;
      lcd_data  <= data_s;
      lcd_on    <= 1'b1;
      lcd_rw    <= 1'b0;
      lcd_blon  <= 1'b0;
      req_ready <= ready_s;
      init_done <= done_s;
    end
  end

endmodule

// File: doc/lcd_controller.md
LCD_CONTROLLER -- requirements
Module: lcd_controller

Interface
REQ-001 The block SHALL use one clock and one reset; the reset SHALL be synchronous and active-high.
REQ-002 Parameter POWERUP_CYCLES, default 750000, SHALL set the power-on wait (15 ms at 50 MHz).
REQ-003 Parameter EN_CYCLES, default 12, SHALL set the lcd_en high width in clocks.
REQ-004 Parameter SHORT_WAIT, default 2000, SHALL set the post-write wait for ordinary writes (40 us).
REQ-005 Parameter LONG_WAIT, default 82000, SHALL set the post-write wait for clear/home commands (1.64 ms).
REQ-006 Ports, clock and reset first:
clk        in   1  system clock, 50 MHz
rst        in   1  synchronous reset, active-high
req_valid  in   1  write request present
req_ready  out  1  block accepts a request this cycle
req_rs     in   1  0 = command, 1 = character data
req_data   in   8  byte to write
init_done  out  1  init sequence complete; sticky until reset
lcd_data   out  8  LCD data bus; write-only
lcd_en     out  1  LCD enable strobe
lcd_rs     out  1  LCD register select
lcd_rw     out  1  LCD read/write; tied 0
lcd_on     out  1  LCD power
lcd_blon   out  1  backlight; tied 0

Function
REQ-007 States SHALL be POWERUP, SETUP, PULSE, HOLD and IDLE. Every output SHALL be registered.
REQ-008 POWERUP SHALL count POWERUP_CYCLES clocks, then load init entry 0 and enter SETUP.
REQ-009 The init ROM SHALL issue six commands (rs=0) in order: 0x38, 0x38, 0x38, 0x0C, 0x01, 0x06.
REQ-010 SETUP SHALL last exactly 2 clocks, with lcd_rs and lcd_data driven to the current byte and lcd_en=0.
REQ-011 PULSE SHALL hold lcd_en=1 for exactly EN_CYCLES consecutive clocks; lcd_rs and lcd_data SHALL be stable throughout.
REQ-012 HOLD SHALL keep lcd_en=0 and lcd_rs/lcd_data unchanged.
  - HOLD lasts LONG_WAIT clocks when rs=0 and data is 0x01, 0x02 or 0x03.
  - HOLD lasts SHORT_WAIT clocks otherwise.
REQ-013 At the end of HOLD during init:
  - If ROM entries remain, the next entry SHALL load and the state SHALL return to SETUP.
  - After entry 5, init_done SHALL be set and the state SHALL enter IDLE.
REQ-014 req_ready SHALL be 1 only in IDLE with init_done=1. It SHALL be 0 in every other state, including the cycle after an acceptance.
REQ-015 A request SHALL be accepted on a clock edge where req_valid=1 and req_ready=1.
  - req_rs and req_data SHALL be latched on that edge and the state SHALL enter SETUP.
  - Inputs SHALL be ignored when req_ready=0; there is no queueing.
REQ-016 Acceptance-to-ready latency SHALL be exactly 2 + EN_CYCLES + wait clocks, where wait is SHORT_WAIT or LONG_WAIT per REQ-012.
REQ-017 A request presented during POWERUP or init SHALL wait; req_valid held high SHALL be accepted on the first cycle init_done=1.
REQ-018 Back-to-back requests with req_valid held high SHALL be accepted on every cycle req_ready returns to 1, with no extra idle clock.
REQ-019 Counters SHALL be wide enough for the largest parameter.
  - Each wait SHALL count from 0 to N-1, then leave the state.
  - Counters SHALL NOT wrap.
REQ-020 lcd_rw SHALL be 0 and lcd_blon SHALL be 0 at all times; lcd_on SHALL be 1 after the first clock out of reset.

Reset
REQ-021 While rst=1 at a clock edge, the block SHALL enter POWERUP and set:
  - lcd_en=0, lcd_rs=0, lcd_data=0x00, lcd_on=0;
  - req_ready=0, init_done=0;
  - counters and the init index to 0.
REQ-022 Reset asserted in any state, including mid-PULSE, SHALL force lcd_en=0 on the next edge. The full power-up and init sequence SHALL then repeat.

Verification (POWERUP_CYCLES=100, EN_CYCLES=4, SHORT_WAIT=10, LONG_WAIT=30)
REQ-023 Release reset and hold req_valid=0 -> no lcd_en edge for 100 clocks; then six 4-clock pulses carrying 0x38, 0x38, 0x38, 0x0C, 0x01, 0x06 with rs=0; the gap after 0x01 is 30 clocks, all other gaps 10; init_done rises after the last HOLD.
REQ-024 After init, present rs=1, data=0x41 for one accepted cycle -> req_ready falls the next cycle; lcd_rs=1 and lcd_data=0x41 for 2 clocks before lcd_en rises; lcd_en stays high for 4 clocks; req_ready returns exactly 16 clocks after acceptance.
REQ-025 Hold req_valid=1 with rs=0, data=0x01 from reset -> accepted on the first cycle init_done=1; req_ready returns 36 clocks after acceptance.
REQ-026 Hold req_valid=1 and present three characters back-to-back -> three accepts spaced exactly 16 clocks apart; no byte is lost or duplicated.
REQ-027 Assert rst for 1 clock during the second clock of a PULSE -> lcd_en=0 and init_done=0 on the next edge; the full power-up and init sequence then repeats.
REQ-028 Change req_data while req_ready=0 -> lcd_data stays at the latched value and no extra pulse occurs.
